// File: rtl/mem_load_stage.sv
// mem_load_stage: dual-issue memory stage feeding the writeback register.
// Latches both issue slots leaving execute and holds them while the slot-0
// data-cache access is outstanding. Aligns and extends load data, and drops
// responses that belong to flushed accesses.
//
// Handshake semantics:
//   capture   : the stage register accepts the execute bundle on an edge
//               where pause=0 and the FSM is IDLE or DONE (flush wins and
//               clears it instead).
//   data_ok   : one-cycle pulse from the data cache. Exactly one pulse
//               answers each issued access. A pulse seen in IDLE/DONE is
//               ignored.
//   pause_mem : stall request to ctrl, high while an access is outstanding
//               (WAIT or CANCEL). It is decoded from state only.
//   wb_valid  : a slot is presented to writeback only in IDLE/DONE. Both
//               slots are released together, so program order is kept.
module mem_load_stage #(
   parameter int ISSUE_WIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ISSUE_WIDTH-1:0]    ex_valid_i,
   input  logic [ISSUE_WIDTH*32-1:0] ex_pc_i,
   input  logic [ISSUE_WIDTH-1:0]    ex_reg_we_i,
   input  logic [ISSUE_WIDTH*5-1:0]  ex_reg_waddr_i,
   input  logic [ISSUE_WIDTH*32-1:0] ex_wdata_i,
   input  logic [2:0]                ex_mem_op_i,
   input  logic [1:0]                ex_addr_lo_i,
   input  logic                      dcache_data_ok_i,
   input  logic [31:0]               dcache_rdata_i,
   input  logic                      flush,
   input  logic                      pause,
   output logic                      pause_mem_o,
   output logic [ISSUE_WIDTH-1:0]    wb_valid_o,
   output logic [ISSUE_WIDTH*32-1:0] wb_pc_o,
   output logic [ISSUE_WIDTH-1:0]    wb_reg_we_o,
   output logic [ISSUE_WIDTH*5-1:0]  wb_reg_waddr_o,
   output logic [ISSUE_WIDTH*32-1:0] wb_wdata_o,
   output logic [1:0]                dbg_state_o
);

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_LB   = 3'd1;
   localparam logic [2:0] OP_LH   = 3'd2;
   localparam logic [2:0] OP_LW   = 3'd3;
   localparam logic [2:0] OP_LBU  = 3'd4;
   localparam logic [2:0] OP_LHU  = 3'd5;
   localparam logic [2:0] OP_ST   = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_DONE   = 2'd2,
      S_CANCEL = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [ISSUE_WIDTH-1:0]    r_valid;
   logic [ISSUE_WIDTH*32-1:0] r_pc;
   logic [ISSUE_WIDTH-1:0]    r_we;
   logic [ISSUE_WIDTH*5-1:0]  r_waddr;
   logic [ISSUE_WIDTH*32-1:0] r_wdata;
   logic [2:0]                r_mem_op;
   logic [1:0]                r_addr_lo;
   logic [31:0]               r_ldbuf;

   logic        w_release;
   logic        w_capture;
   logic        w_new_mem;
   logic        w_is_load;
   logic [31:0] w_shifted;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_val;

   // Stage is open to writeback and to new bundles only when no access is outstanding.
   assign w_release = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_capture = !pause && w_release;
   // A memory op counts only when slot 0 is actually valid.
   assign w_new_mem = ex_valid_i[0] && (ex_mem_op_i != OP_NONE);
   assign w_is_load = (r_mem_op != OP_NONE) && (r_mem_op != OP_ST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode. A flushed access still owes one data_ok, which CANCEL absorbs.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (flush)          w_state_nxt = S_IDLE;
            else if (w_capture) w_state_nxt = w_new_mem ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            if (dcache_data_ok_i) w_state_nxt = flush ? S_IDLE : S_DONE;
            else if (flush)       w_state_nxt = S_CANCEL;
         end
         S_CANCEL: begin
            if (dcache_data_ok_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Stage register: flush clears it ahead of any capture.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid   <= '0;
         r_pc      <= '0;
         r_we      <= '0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_mem_op  <= OP_NONE;
         r_addr_lo <= '0;
      end else if (w_capture) begin
         r_valid   <= ex_valid_i;
         r_pc      <= ex_pc_i;
         r_we      <= ex_reg_we_i;
         r_waddr   <= ex_reg_waddr_i;
         r_wdata   <= ex_wdata_i;
         r_mem_op  <= ex_valid_i[0] ? ex_mem_op_i : OP_NONE;
         r_addr_lo <= ex_addr_lo_i;
      end
   end

   // Load buffer takes the response only for a live (unflushed) load in WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ldbuf <= '0;
      end else if ((r_state == S_WAIT) && dcache_data_ok_i && !flush && w_is_load) begin
         r_ldbuf <= dcache_rdata_i;
      end
   end

   // Load alignment: pick byte/half by address and extend to 32 bits.
   always_comb begin
      w_shifted  = r_ldbuf >> {r_addr_lo, 3'b000};
      w_byte     = w_shifted[7:0];
      w_half     = r_addr_lo[1] ? r_ldbuf[31:16] : r_ldbuf[15:0];
      w_load_val = r_ldbuf;
      unique case (r_mem_op)
         OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  w_load_val = {24'd0, w_byte};
         OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
         OP_LHU:  w_load_val = {16'd0, w_half};
         OP_LW:   w_load_val = r_ldbuf;
         default: w_load_val = r_ldbuf;
      endcase
   end

   // Output decode: gate valids by state, suppress store writeback, mux slot-0 data.
   always_comb begin
      pause_mem_o    = (r_state == S_WAIT) || (r_state == S_CANCEL);
      wb_valid_o     = r_valid & {ISSUE_WIDTH{w_release}};
      wb_pc_o        = r_pc;
      wb_reg_waddr_o = r_waddr;
      wb_reg_we_o    = r_we & wb_valid_o;
      wb_wdata_o     = r_wdata;
      dbg_state_o    = r_state;
      if (r_mem_op == OP_ST) wb_reg_we_o[0] = 1'b0;
      if (w_is_load)         wb_wdata_o[31:0] = w_load_val;
   end

endmodule

// File: tb/tb_mem_load_stage.sv
// tb_mem_load_stage: directed vectors with hand-computed expectations.
module tb_mem_load_stage;

   logic        clk;
   logic        rst;
   logic [1:0]  ex_valid_i;
   logic [63:0] ex_pc_i;
   logic [1:0]  ex_reg_we_i;
   logic [9:0]  ex_reg_waddr_i;
   logic [63:0] ex_wdata_i;
   logic [2:0]  ex_mem_op_i;
   logic [1:0]  ex_addr_lo_i;
   logic        dcache_data_ok_i;
   logic [31:0] dcache_rdata_i;
   logic        flush;
   logic        pause;
   logic        pause_mem_o;
   logic [1:0]  wb_valid_o;
   logic [63:0] wb_pc_o;
   logic [1:0]  wb_reg_we_o;
   logic [9:0]  wb_reg_waddr_o;
   logic [63:0] wb_wdata_o;
   logic [1:0]  dbg_state_o;

   int n_vec = 0;
   int n_err = 0;

   mem_load_stage #(.ISSUE_WIDTH(2)) dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid_i       (ex_valid_i),
      .ex_pc_i          (ex_pc_i),
      .ex_reg_we_i      (ex_reg_we_i),
      .ex_reg_waddr_i   (ex_reg_waddr_i),
      .ex_wdata_i       (ex_wdata_i),
      .ex_mem_op_i      (ex_mem_op_i),
      .ex_addr_lo_i     (ex_addr_lo_i),
      .dcache_data_ok_i (dcache_data_ok_i),
      .dcache_rdata_i   (dcache_rdata_i),
      .flush            (flush),
      .pause            (pause),
      .pause_mem_o      (pause_mem_o),
      .wb_valid_o       (wb_valid_o),
      .wb_pc_o          (wb_pc_o),
      .wb_reg_we_o      (wb_reg_we_o),
      .wb_reg_waddr_o   (wb_reg_waddr_o),
      .wb_wdata_o       (wb_wdata_o),
      .dbg_state_o      (dbg_state_o)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      ex_valid_i       = 2'b00;
      ex_pc_i          = '0;
      ex_reg_we_i      = 2'b00;
      ex_reg_waddr_i   = '0;
      ex_wdata_i       = '0;
      ex_mem_op_i      = 3'd0;
      ex_addr_lo_i     = 2'd0;
      dcache_data_ok_i = 1'b0;
      dcache_rdata_i   = '0;
   endtask

   task automatic drive_alu(input logic [31:0] d0, input logic [31:0] d1);
      ex_valid_i     = 2'b11;
      ex_pc_i        = {32'h0000_0104, 32'h0000_0100};
      ex_reg_we_i    = 2'b11;
      ex_reg_waddr_i = {5'd4, 5'd3};
      ex_wdata_i     = {d1, d0};
      ex_mem_op_i    = 3'd0;
   endtask

   task automatic drive_mem(input logic [2:0] op, input logic [1:0] lo, input logic [31:0] d0);
      ex_valid_i     = 2'b01;
      ex_pc_i        = {32'h0, 32'h0000_0200};
      ex_reg_we_i    = (op == 3'd6) ? 2'b00 : 2'b01;
      ex_reg_waddr_i = {5'd0, 5'd5};
      ex_wdata_i     = {32'h0, d0};
      ex_mem_op_i    = op;
      ex_addr_lo_i   = lo;
   endtask

   // Full memory access: capture, k cycles of waiting with data_ok in the last, then DONE checks.
   task automatic do_mem(input string tag, input logic [2:0] op, input logic [1:0] lo,
                         input logic [31:0] rdata, input int k,
                         input logic [31:0] exp_data, input logic [1:0] exp_we);
      drive_mem(op, lo, 32'h0000_0055);
      tick();
      drive_idle();
      for (int i = 0; i < k; i++) begin
         check_vec({tag, "_pause"}, pause_mem_o, 1'b1);
         check_vec({tag, "_hold_valid"}, wb_valid_o, 2'b00);
         if (i == k - 1) begin
            dcache_data_ok_i = 1'b1;
            dcache_rdata_i   = rdata;
         end
         tick();
      end
      dcache_data_ok_i = 1'b0;
      dcache_rdata_i   = '0;
      check_vec({tag, "_state"}, dbg_state_o, 2'd2);
      check_vec({tag, "_pause_off"}, pause_mem_o, 1'b0);
      check_vec({tag, "_valid"}, wb_valid_o, 2'b01);
      check_vec({tag, "_we"}, wb_reg_we_o, exp_we);
      check_vec({tag, "_data"}, wb_wdata_o[31:0], exp_data);
   endtask

   initial begin
      drive_idle();
      flush = 1'b0;
      pause = 1'b0;
      rst   = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state.
      check_vec("rst_valid", wb_valid_o, 2'b00);
      check_vec("rst_pause", pause_mem_o, 1'b0);
      check_vec("rst_we", wb_reg_we_o, 2'b00);
      check_vec("rst_pc", wb_pc_o, 64'h0);
      check_vec("rst_waddr", wb_reg_waddr_o, 10'h0);
      check_vec("rst_wdata", wb_wdata_o, 64'h0);
      check_vec("rst_state", dbg_state_o, 2'd0);

      // ALU pair, one-cycle latency.
      drive_alu(32'h11, 32'h22);
      tick();
      drive_idle();
      check_vec("alu_valid", wb_valid_o, 2'b11);
      check_vec("alu_we", wb_reg_we_o, 2'b11);
      check_vec("alu_waddr", wb_reg_waddr_o, {5'd4, 5'd3});
      check_vec("alu_wdata", wb_wdata_o, {32'h22, 32'h11});
      check_vec("alu_pc", wb_pc_o, {32'h104, 32'h100});
      check_vec("alu_pause", pause_mem_o, 1'b0);
      tick();
      check_vec("alu_drain", wb_valid_o, 2'b00);

      // data_ok while idle is ignored.
      dcache_data_ok_i = 1'b1;
      dcache_rdata_i   = 32'h1234_5678;
      tick();
      drive_idle();
      check_vec("idle_dok_state", dbg_state_o, 2'd0);
      check_vec("idle_dok_pause", pause_mem_o, 1'b0);

      // Loads and store.
      do_mem("lb",  3'd1, 2'd3, 32'h80FF_0000, 2, 32'hFFFF_FF80, 2'b01);
      do_mem("lbu", 3'd4, 2'd3, 32'h80FF_0000, 2, 32'h0000_0080, 2'b01);
      do_mem("lh",  3'd2, 2'd2, 32'h8001_1234, 1, 32'hFFFF_8001, 2'b01);
      do_mem("lhu", 3'd5, 2'd0, 32'h8001_1234, 1, 32'h0000_1234, 2'b01);
      do_mem("lb1", 3'd1, 2'd1, 32'h0000_7F00, 1, 32'h0000_007F, 2'b01);
      do_mem("lw",  3'd3, 2'd0, 32'hA5A5_0F0F, 1, 32'hA5A5_0F0F, 2'b01);
      do_mem("st",  3'd6, 2'd0, 32'h0000_0000, 1, 32'h0000_0055, 2'b00);

      // Flush in WAIT, response arrives 3 cycles later and is absorbed.
      tick();
      drive_mem(3'd3, 2'd0, 32'h0);
      tick();
      drive_idle();
      check_vec("fl_wait_pause", pause_mem_o, 1'b1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_vec("fl_cancel_state", dbg_state_o, 2'd3);
      check_vec("fl_cancel_pause", pause_mem_o, 1'b1);
      check_vec("fl_cancel_valid", wb_valid_o, 2'b00);
      tick();
      check_vec("fl_cancel_pause2", pause_mem_o, 1'b1);
      dcache_data_ok_i = 1'b1;
      dcache_rdata_i   = 32'hDEAD_BEEF;
      tick();
      drive_idle();
      check_vec("fl_idle_state", dbg_state_o, 2'd0);
      check_vec("fl_idle_pause", pause_mem_o, 1'b0);
      check_vec("fl_idle_valid", wb_valid_o, 2'b00);
      check_vec("fl_idle_wdata", wb_wdata_o[31:0], 32'h0);
      drive_alu(32'h33, 32'h44);
      tick();
      drive_idle();
      check_vec("fl_alu_valid", wb_valid_o, 2'b11);
      check_vec("fl_alu_wdata", wb_wdata_o, {32'h44, 32'h33});
      check_vec("fl_alu_we", wb_reg_we_o, 2'b11);

      // Flush coinciding with data_ok in WAIT.
      drive_mem(3'd3, 2'd0, 32'h0);
      tick();
      drive_idle();
      flush            = 1'b1;
      dcache_data_ok_i = 1'b1;
      dcache_rdata_i   = 32'hCAFE_F00D;
      tick();
      flush = 1'b0;
      drive_idle();
      check_vec("fdok_state", dbg_state_o, 2'd0);
      check_vec("fdok_pause", pause_mem_o, 1'b0);
      check_vec("fdok_valid", wb_valid_o, 2'b00);
      check_vec("fdok_wdata", wb_wdata_o[31:0], 32'h0);

      // Pause held in DONE, then back-to-back load straight into WAIT.
      do_mem("pz", 3'd3, 2'd0, 32'h1234_5678, 1, 32'h1234_5678, 2'b01);
      pause = 1'b1;
      drive_mem(3'd2, 2'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_vec("pz_state", dbg_state_o, 2'd2);
         check_vec("pz_valid", wb_valid_o, 2'b01);
         check_vec("pz_wdata", wb_wdata_o[31:0], 32'h1234_5678);
         check_vec("pz_mempause", pause_mem_o, 1'b0);
      end
      pause = 1'b0;
      tick();
      drive_idle();
      check_vec("b2b_state", dbg_state_o, 2'd1);
      check_vec("b2b_pause", pause_mem_o, 1'b1);
      check_vec("b2b_valid", wb_valid_o, 2'b00);
      dcache_data_ok_i = 1'b1;
      dcache_rdata_i   = 32'h0000_ABCD;
      tick();
      drive_idle();
      check_vec("b2b_done_state", dbg_state_o, 2'd2);
      check_vec("b2b_done_data", wb_wdata_o[31:0], 32'hFFFF_ABCD);
      check_vec("b2b_done_valid", wb_valid_o, 2'b01);

      // Final report.
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
